// File: rtl/pipe_latch_ctrl.sv
// Stall/flush controller for the five-stage pipeline latch banks.
// Resolves load-use, X redirects and multicycle mult/div occupancy.
module pipe_latch_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dx_is_load,
    input  logic [4:0]       dx_rd,
    input  logic [4:0]       fd_rs1,
    input  logic [4:0]       fd_rs2,
    input  logic             fd_uses_rs1,
    input  logic             fd_uses_rs2,
    input  logic             x_redirect,
    input  logic             md_start,
    input  logic             md_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_clr,
    output logic             dx_clr,
    output logic             xm_clr,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MD_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] MD_BUSY = 2'd1;
    localparam logic [1:0] FAULT   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             md_timeout_q, md_timeout_d;

    logic load_use;
    logic freeze;

    assign load_use = dx_is_load && (dx_rd != 5'd0) &&
                      ((fd_uses_rs1 && (fd_rs1 == dx_rd)) ||
                       (fd_uses_rs2 && (fd_rs2 == dx_rd)));

    // md_start only matters in RUN; in MD_BUSY the unit is already occupied
    assign freeze = ((state_q == RUN) && md_start && !md_ready) ||
                    ((state_q == MD_BUSY) && !md_ready);

    always_comb begin
        pc_en  = 1'b1;
        fd_en  = 1'b1;
        dx_en  = 1'b1;
        xm_en  = 1'b1;
        mw_en  = 1'b1;
        fd_clr = 1'b0;
        dx_clr = 1'b0;
        xm_clr = 1'b0;
        if (!reset_n) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_en  = 1'b0;
            xm_en  = 1'b0;
            mw_en  = 1'b0;
            fd_clr = 1'b1;
            dx_clr = 1'b1;
            xm_clr = 1'b1;
        end else if (state_q == FAULT) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            dx_en = 1'b0;
            xm_en = 1'b0;
            mw_en = 1'b0;
        end else if (freeze) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_en  = 1'b0;
            xm_en  = 1'b0;
            xm_clr = 1'b1;
        end else if (x_redirect) begin
            fd_clr = 1'b1;
            dx_clr = 1'b1;
        end else if (load_use) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_clr = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        md_timeout_d  = md_timeout_q;
        stall_count_d = stall_count_q;
        case (state_q)
            RUN: begin
                if (md_start && !md_ready) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_W'(1);
                end
            end
            MD_BUSY: begin
                if (md_ready) begin
                    state_d  = RUN;
                    md_cnt_d = '0;
                end else if (md_cnt_q == MD_LAST) begin
                    state_d      = FAULT;
                    md_timeout_d = 1'b1;
                end else begin
                    md_cnt_d = md_cnt_q + MD_W'(1);
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = '0;
            end
        endcase
        if (!pc_en && (state_q != FAULT) && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            md_cnt_q      <= '0;
            md_timeout_q  <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            md_timeout_q  <= md_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign md_busy     = (state_q == MD_BUSY);
    assign md_timeout  = md_timeout_q;
    assign stall_count = stall_count_q;

endmodule
